seq_divider: RTL and testbench

- Iterative unsigned restoring divider, one quotient bit per clock.
- Each step trial-subtracts the divisor from the partial remainder. A borrow means the step is undone (restore) and the quotient bit is 0; otherwise the difference is kept and the quotient bit is 1.
- Sits beside the combinational arithmetic blocks as the multi-cycle quotient/remainder unit for the datapath.
- Uses a start/busy/done handshake toward a controller.

---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/seq_divider_div_step.sv | 29 ++
 rtl/seq_divider.sv | 151 +++++++++++++++
 tb/tb_seq_divider.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the step-counter width helper.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One extra bit so the counter can hold WIDTH itself without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, and keep or restore depending on the borrow.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;

    // Shift, trial subtract, and restore mux; the top bit only exposes the borrow.
    always_comb begin
        shifted_s = {rem, dvd_bit};
        trial_s   = shifted_s - {1'b0, divisor};
        if (trial_s[WIDTH]) begin
            rem_next = shifted_s[WIDTH-1:0];
            q_bit    = 1'b0;
        end else begin
            rem_next = trial_s[WIDTH-1:0];
            q_bit    = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake;
// one quotient bit per clock, results held until the next completion.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_r;
    state_e           next_state_s;
    logic             busy_r;
    logic             done_r;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic             accept_s;
    logic             zero_div_s;
    logic             last_step_s;

    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic [WIDTH-1:0] rem_nxt_s;
    logic             q_bit_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .dvd_bit  (dvd_r[WIDTH-1]),
        .divisor  (dvs_r),
        .rem_next (rem_nxt_s),
        .q_bit    (q_bit_s)
    );

    // Next-state logic; a start is honoured in IDLE and DONE only.
    always_comb begin
        next_state_s = ST_IDLE;
        accept_s     = 1'b0;
        zero_div_s   = (i_divisor == {WIDTH{1'b0}});
        last_step_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    accept_s     = 1'b1;
                    next_state_s = zero_div_s ? ST_DONE : ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    last_step_s  = 1'b1;
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the upcoming state so they register cleanly.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (next_state_s)
            ST_RUN:  busy_nxt_s = 1'b1;
            ST_DONE: done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // State register together with the registered handshake flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Operand capture, iteration registers, and the held result registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dvd_r       <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
        end else if (accept_s) begin
            if (zero_div_s) begin
                quotient_r  <= {WIDTH{1'b1}};
                remainder_r <= i_dividend;
                dbz_r       <= 1'b1;
            end else begin
                dvd_r <= i_dividend;
                dvs_r <= i_divisor;
                rem_r <= {WIDTH{1'b0}};
                quo_r <= {WIDTH{1'b0}};
                cnt_r <= {CNT_W{1'b0}};
            end
        end else if (state_r == ST_RUN) begin
            dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
            rem_r <= rem_nxt_s;
            quo_r <= {quo_r[WIDTH-2:0], q_bit_s};
            cnt_r <= cnt_r + CNT_ONE;
            // Results publish only on the final step so they never show partial values.
            if (last_step_s) begin
                quotient_r  <= {quo_r[WIDTH-2:0], q_bit_s};
                remainder_r <= rem_nxt_s;
                dbz_r       <= 1'b0;
            end
        end
    end

    assign o_busy        = busy_r;
    assign o_done        = done_r;
    assign o_quotient    = quotient_r;
    assign o_remainder   = remainder_r;
    assign o_div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized
// operations compared against plain integer division.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_by_zero;

    int n_chk  = 0;
    int n_pass = 0;

    seq_divider #(.WIDTH(W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_dividend    (dvd),
        .i_divisor     (dvs),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_div_by_zero (o_div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Present operands with start for one edge, then scramble the inputs.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        dvd   = a;
        dvs   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        dvd   = W'($urandom);
        dvs   = W'($urandom);
    endtask

    // Called in the cycle after the accepting edge; waits for done and checks.
    task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int pulse_at);
        int           c       = 1;
        int           busy_n  = 0;
        int           changes = 0;
        int           elat;
        logic [W-1:0] q0;
        logic [W-1:0] r0;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        if (b == 8'd0) begin
            eq = {W{1'b1}}; er = a; ez = 1'b1; elat = 1;
        end else begin
            eq = a / b; er = a % b; ez = 1'b0; elat = W + 1;
        end
        q0 = o_quotient;
        r0 = o_remainder;
        while (!o_done && c < 4 * W) begin
            if (o_busy) busy_n++;
            if (o_quotient !== q0 || o_remainder !== r0) changes++;
            if (c == pulse_at) begin
                start = 1'b1; dvd = 8'd10; dvs = 8'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0;
        check_val({tag, " latency"}, c, elat);
        check_val({tag, " busy_cycles"}, busy_n, (b == 8'd0) ? 0 : W);
        check_val({tag, " busy_at_done"}, o_busy, 0);
        check_val({tag, " quotient"}, o_quotient, eq);
        check_val({tag, " remainder"}, o_remainder, er);
        check_val({tag, " div_by_zero"}, o_div_by_zero, ez);
        check_val({tag, " hold"}, changes, 0);
    endtask

    initial begin
        int           dn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst = 1'b1; start = 1'b0; dvd = 8'd0; dvs = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst busy", o_busy, 0);
        check_val("rst done", o_done, 0);
        check_val("rst quotient", o_quotient, 0);
        check_val("rst remainder", o_remainder, 0);
        check_val("rst dbz", o_div_by_zero, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(8'd100, 8'd7);   run_check("100/7", 8'd100, 8'd7, 0);
        @(posedge clk); #1;
        check_val("done_pulse", o_done, 0);
        issue(8'd255, 8'd1);   run_check("255/1", 8'd255, 8'd1, 0);
        @(posedge clk); #1;
        issue(8'd5, 8'd9);     run_check("5/9", 8'd5, 8'd9, 0);
        @(posedge clk); #1;
        issue(8'd255, 8'd255); run_check("255/255", 8'd255, 8'd255, 0);
        @(posedge clk); #1;
        issue(8'd37, 8'd0);    run_check("37/0", 8'd37, 8'd0, 0);
        @(posedge clk); #1;
        check_val("dbz done_pulse", o_done, 0);
        check_val("dbz held", o_div_by_zero, 1);
        issue(8'd200, 8'd3);   run_check("200/3 ignore_start", 8'd200, 8'd3, 4);
        @(posedge clk); #1;

        // Abort an operation at RUN cycle 5 with reset.
        issue(8'd100, 8'd7);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("abort busy", o_busy, 0);
        check_val("abort done", o_done, 0);
        check_val("abort quotient", o_quotient, 0);
        check_val("abort remainder", o_remainder, 0);
        check_val("abort dbz", o_div_by_zero, 0);
        dn = 0;
        repeat (12) begin
            if (o_done || o_busy) dn++;
            @(posedge clk); #1;
        end
        check_val("abort no_done", dn, 0);
        issue(8'd9, 8'd4);     run_check("9/4", 8'd9, 8'd4, 0);
        @(posedge clk); #1;

        // Back-to-back: new start accepted in the DONE cycle.
        issue(8'd100, 8'd7);   run_check("chain 100/7", 8'd100, 8'd7, 0);
        issue(8'd50, 8'd6);    run_check("chain 50/6", 8'd50, 8'd6, 0);
        @(posedge clk); #1;

        repeat (40) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
            issue(a, b);
            run_check("random", a, b, int'($urandom_range(0, W - 1)));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
